// File: rtl/security_pkg.sv
// Shared definitions for the security panel.
// State codes, widths and a constant clog2 helper.
package security_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_DISARMED = 3'd0;
    localparam logic [STATE_W-1:0] ST_EXIT     = 3'd1;
    localparam logic [STATE_W-1:0] ST_ARMED    = 3'd2;
    localparam logic [STATE_W-1:0] ST_ENTRY    = 3'd3;
    localparam logic [STATE_W-1:0] ST_ALARM    = 3'd4;

    // Bits needed to hold values 0 .. v-1 (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/security_panel_zone_debounce.sv
// Per-zone debounce: trip asserts once the input
// has been high for DEBOUNCE consecutive samples.
module zone_debounce
    import security_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic trip
);

    localparam int CW = max2(clog2(DEBOUNCE + 1), 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive high samples, saturating; any low sample clears.
    always_comb begin
        cnt_d = cnt_q;
        if (!in) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign trip = (cnt_q == CNT_MAX);

endmodule

// File: rtl/security_panel.sv
// Alarm controller: arm/disarm FSM with exit and entry
// delays, zone trip latching and a time-bounded siren.
module security_panel
    import security_pkg::*;
#(
    parameter int N_ZONES    = 4,
    parameter int ENTRY_ZONE = 0,
    parameter int DEBOUNCE   = 3,
    parameter int EXIT_CYC   = 20,
    parameter int ENTRY_CYC  = 30,
    parameter int SIREN_CYC  = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] zone_alarm,
    input  logic               arm,
    input  logic               disarm,
    output logic               armed,
    output logic               pending,
    output logic               siren,
    output logic [N_ZONES-1:0] zone_latched,
    output logic [STATE_W-1:0] state
);

    localparam int MAXC = max2(max2(EXIT_CYC, ENTRY_CYC), SIREN_CYC);
    localparam int TW   = max2(clog2(MAXC), 1);

    localparam logic [TW-1:0] EXIT_LD  = TW'(EXIT_CYC - 1);
    localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_CYC - 1);
    localparam logic [TW-1:0] SIREN_LD = TW'(SIREN_CYC - 1);

    localparam logic [N_ZONES-1:0] ENTRY_MASK = N_ZONES'(1) << ENTRY_ZONE;

    logic [N_ZONES-1:0] trip;
    logic               inst_trip;
    logic               entry_trip;
    logic               tick;

    logic [STATE_W-1:0] state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               siren_q, siren_d;
    logic               armed_q, armed_d;
    logic               pending_q, pending_d;
    logic [N_ZONES-1:0] latched_q, latched_d;

    for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
        zone_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .in   (zone_alarm[g]),
            .trip (trip[g])
        );
    end

    assign inst_trip  = |(trip & ~ENTRY_MASK);
    assign entry_trip = |(trip & ENTRY_MASK);
    assign tick       = (timer_q == '0);

    // Next-state, shared timer, siren and latch update.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        siren_d   = siren_q;
        latched_d = latched_q;

        if (state_q inside {ST_ARMED, ST_ENTRY, ST_ALARM}) begin
            latched_d = latched_q | trip;
        end

        if (disarm) begin
            state_d = ST_DISARMED;
            timer_d = '0;
            siren_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_DISARMED: begin
                    if (arm) begin
                        state_d   = ST_EXIT;
                        timer_d   = EXIT_LD;
                        latched_d = '0;
                    end
                end
                ST_EXIT: begin
                    if (tick) begin
                        state_d = ST_ARMED;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (inst_trip) begin
                        state_d = ST_ALARM;
                        timer_d = SIREN_LD;
                        siren_d = 1'b1;
                    end else if (entry_trip) begin
                        state_d = ST_ENTRY;
                        timer_d = ENTRY_LD;
                    end
                end
                ST_ENTRY: begin
                    if (inst_trip || tick) begin
                        state_d = ST_ALARM;
                        timer_d = SIREN_LD;
                        siren_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (siren_q) begin
                        if (tick) begin
                            siren_d = 1'b0;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    timer_d = '0;
                    siren_d = 1'b0;
                end
            endcase
        end

        armed_d   = (state_d != ST_DISARMED) &&
                    (state_d inside {ST_EXIT, ST_ARMED, ST_ENTRY, ST_ALARM});
        pending_d = (state_d == ST_EXIT) || (state_d == ST_ENTRY);
    end

    // State, timer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_DISARMED;
            timer_q   <= '0;
            siren_q   <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
            latched_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            siren_q   <= siren_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            latched_q <= latched_d;
        end
    end

    assign state        = state_q;
    assign armed        = armed_q;
    assign pending      = pending_q;
    assign siren        = siren_q;
    assign zone_latched = latched_q;

endmodule

// File: tb/tb_security_panel.sv
// Self-checking bench for security_panel: directed scenarios
// with literal expectations plus a randomized run against a model.
module tb_security_panel;

    localparam int NZ  = 4;
    localparam int EZ  = 0;
    localparam int DB  = 3;
    localparam int EXC = 20;
    localparam int ENC = 30;
    localparam int SC  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] zone = 4'b0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       armed, pending, siren;
    logic [3:0] lat;
    logic [2:0] st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    security_panel #(
        .N_ZONES   (NZ),
        .ENTRY_ZONE(EZ),
        .DEBOUNCE  (DB),
        .EXIT_CYC  (EXC),
        .ENTRY_CYC (ENC),
        .SIREN_CYC (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .zone_alarm  (zone),
        .arm         (arm),
        .disarm      (disarm),
        .armed       (armed),
        .pending     (pending),
        .siren       (siren),
        .zone_latched(lat),
        .state       (st)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run lengths of high samples, state number
    // and the number of cycles spent in the current state.
    int         run [NZ];
    int         m_st = 0;
    int         m_age = 0;
    logic [3:0] m_lat = 4'b0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [3:0] tr;
        int         nst;
        bit         inst;
        for (int i = 0; i < NZ; i++) begin
            tr[i] = (run[i] >= DB);
            run[i] = zone[i] ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
        end
        if (!rst_n) begin
            for (int i = 0; i < NZ; i++) run[i] = 0;
            m_st = 0;
            m_age = 0;
            m_lat = 4'b0;
            m_valid = 1'b1;
        end else begin
            if (m_st >= 2 && m_st <= 4) m_lat = m_lat | tr;
            inst = ((tr & ~(4'b0001 << EZ)) != 4'b0);
            nst = m_st;
            if (disarm) begin
                nst = 0;
            end else begin
                case (m_st)
                    0: if (arm) begin nst = 1; m_lat = 4'b0; end
                    1: if (m_age == EXC - 1) nst = 2;
                    2: if (inst) nst = 4; else if (tr[EZ]) nst = 3;
                    3: if (inst || m_age == ENC - 1) nst = 4;
                    4: nst = 4;
                    default: nst = 0;
                endcase
            end
            if (nst != m_st) m_age = 0;
            else if (m_age < 1000000) m_age = m_age + 1;
            m_st = nst;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state", st, m_st);
            chk("m_armed", armed, (m_st >= 1 && m_st <= 4));
            chk("m_pending", pending, (m_st == 1 || m_st == 3));
            chk("m_siren", siren, (m_st == 4 && m_age < SC));
            chk("m_latched", lat, m_lat);
        end
    end

    task automatic step(input logic [3:0] z, input logic a, input logic d);
        zone = z;
        arm = a;
        disarm = d;
        @(posedge clk);
        #1;
    endtask

    task automatic arm_and_exit();
        step(4'b0, 1'b1, 1'b0);
        repeat (EXC) step(4'b0, 1'b0, 1'b0);
    endtask

    task automatic reach_entry();
        int k;
        k = 0;
        while (st !== 3'd3 && k < 10) begin
            step(4'b0001, 1'b0, 1'b0);
            k++;
        end
        chk("entry_latency", k, 4);
    endtask

    initial begin
        int n, k;
        bit seen;
        logic [3:0] zr;

        // Reset then idle
        repeat (3) step(4'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst_state", st, 0);
        chk("rst_armed", armed, 0);
        chk("rst_pending", pending, 0);
        chk("rst_siren", siren, 0);
        chk("rst_lat", lat, 0);
        repeat (6) step(4'b1111, 1'b0, 1'b0);
        chk("idle_siren", siren, 0);
        chk("idle_lat", lat, 0);
        chk("idle_state", st, 0);
        repeat (2) step(4'b0, 1'b0, 1'b0);

        // Exit delay length; zone activity ignored
        step(4'b0, 1'b1, 1'b0);
        chk("arm_state", st, 1);
        chk("arm_pending", pending, 1);
        n = 0;
        while (st === 3'd1 && n < 40) begin
            step((n < 10) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
            n++;
        end
        chk("exit_len", n, EXC);
        chk("armed_state", st, 2);
        chk("armed_pending", pending, 0);
        chk("armed_out", armed, 1);

        // Short glitch then held instant zone
        repeat (2) step(4'b0100, 1'b0, 1'b0);
        step(4'b0, 1'b0, 1'b0);
        chk("glitch_state", st, 2);
        chk("glitch_siren", siren, 0);
        k = 0;
        while (siren !== 1'b1 && k < 10) begin
            step(4'b0100, 1'b0, 1'b0);
            k++;
        end
        chk("siren_latency", k, DB + 1);
        chk("z2_lat", lat, 4'b0100);
        chk("z2_state", st, 4);
        n = 0;
        while (siren === 1'b1 && n < 300) begin
            step(4'b0100, 1'b0, 1'b0);
            n++;
        end
        chk("siren_len", n, SC);
        chk("silent_state", st, 4);
        repeat (5) step(4'b0100, 1'b0, 1'b0);
        chk("no_retrigger", siren, 0);
        step(4'b0, 1'b0, 1'b1);
        chk("disarm_state", st, 0);
        chk("lat_hold", lat, 4'b0100);

        // Entry zone, full entry delay
        step(4'b0, 1'b1, 1'b0);
        chk("arm_clears_lat", lat, 0);
        repeat (EXC) step(4'b0, 1'b0, 1'b0);
        chk("armed2_state", st, 2);
        reach_entry();
        n = 0;
        while (st === 3'd3 && n < 100) begin
            step(4'b0001, 1'b0, 1'b0);
            n++;
        end
        chk("entry_len", n, ENC);
        chk("entry_alarm", st, 4);
        chk("entry_siren", siren, 1);
        chk("entry_lat", lat, 4'b0001);
        step(4'b0, 1'b0, 1'b1);

        // Disarm during entry delay
        arm_and_exit();
        reach_entry();
        seen = 1'b0;
        repeat (9) begin
            step(4'b0001, 1'b0, 1'b0);
            if (siren !== 1'b0) seen = 1'b1;
        end
        step(4'b0001, 1'b0, 1'b1);
        chk("entry_disarm_state", st, 0);
        chk("entry_no_siren", seen, 0);
        chk("entry_disarm_lat", lat, 4'b0001);

        // Instant zone during entry delay
        step(4'b0, 1'b1, 1'b0);
        chk("arm_clears_lat2", lat, 0);
        repeat (EXC) step(4'b0, 1'b0, 1'b0);
        reach_entry();
        k = 0;
        while (st === 3'd3 && k < 10) begin
            step(4'b1001, 1'b0, 1'b0);
            k++;
        end
        chk("inst_in_entry", k, DB + 1);
        chk("inst_state", st, 4);
        chk("inst_lat", lat, 4'b1001);

        // arm and disarm together in ALARM
        step(4'b0, 1'b1, 1'b1);
        chk("both_state", st, 0);
        chk("both_siren", siren, 0);
        chk("both_armed", armed, 0);

        // Reset mid-ALARM
        arm_and_exit();
        repeat (DB + 1) step(4'b0010, 1'b0, 1'b0);
        chk("alarm3_state", st, 4);
        rst_n = 1'b0;
        step(4'b0010, 1'b0, 1'b0);
        chk("mid_rst_state", st, 0);
        chk("mid_rst_siren", siren, 0);
        chk("mid_rst_armed", armed, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_lat", lat, 0);
        rst_n = 1'b1;
        step(4'b0, 1'b0, 1'b0);

        // Randomized run checked by the model
        zr = 4'b0;
        repeat (4000) begin
            for (int i = 0; i < NZ; i++) begin
                if ($urandom % 8 == 0) zr[i] = ~zr[i];
            end
            rst_n = ($urandom % 800 != 0);
            step(zr, ($urandom % 16 == 0), ($urandom % 64 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
